// File: rtl/ball_ctrl.sv
// Breakout ball motion engine: serve, move, wall and paddle bounce,
// and lost-ball sequencing, all advanced once per frame_tick.
module ball_ctrl #(
   parameter int BALL_SIZE   = 25,
   parameter int PADDLE_W    = 121,
   parameter int SPEED_X     = 4,
   parameter int SPEED_Y     = 4,
   parameter int X_MIN       = 10,
   parameter int X_MAX       = 1429,
   parameter int Y_MIN       = 11,
   parameter int Y_MAX       = 889,
   parameter int X_START     = 708,
   parameter int Y_START     = 600,
   parameter int LOST_FRAMES = 60
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        frame_tick_i,
   input  logic        launch_i,
   input  logic [10:0] paddle_x_i,
   input  logic [9:0]  paddle_y_i,
   output logic [10:0] ball_x_o,
   output logic [9:0]  ball_y_o,
   output logic        in_play_o,
   output logic        ball_lost_o
);

   typedef enum logic [1:0] {
      S_SERVE = 2'd0,
      S_MOVE  = 2'd1,
      S_LOST  = 2'd2
   } state_t;

   localparam logic [11:0] BS_C      = 12'(BALL_SIZE);
   localparam logic [11:0] BS_M1     = 12'(BALL_SIZE - 1);
   localparam logic [11:0] PW_M1     = 12'(PADDLE_W - 1);
   localparam logic [11:0] SX_C      = 12'(SPEED_X);
   localparam logic [11:0] SY_C      = 12'(SPEED_Y);
   localparam logic [11:0] XMIN_C    = 12'(X_MIN);
   localparam logic [11:0] XMAX_C    = 12'(X_MAX);
   localparam logic [11:0] YMIN_C    = 12'(Y_MIN);
   localparam logic [11:0] YMAX_C    = 12'(Y_MAX);
   localparam logic [11:0] X_RIGHT   = 12'(X_MAX - BALL_SIZE + 1);
   localparam logic [11:0] Y_FLOOR   = 12'(Y_MAX - BALL_SIZE + 1);
   localparam logic [11:0] SERVE_OFS = 12'((PADDLE_W - BALL_SIZE) / 2);
   localparam logic [11:0] X_RST     = 12'(X_START);
   localparam logic [11:0] Y_RST     = 12'(Y_START);

   localparam int CW = $clog2(LOST_FRAMES + 1);
   localparam logic [CW-1:0] LOST_LAST = CW'(LOST_FRAMES - 1);

   state_t          state_q;
   logic [11:0]     x_q;
   logic [11:0]     y_q;
   logic            dir_x_q;   // 1: moving right
   logic            dir_y_q;   // 1: moving down
   logic [CW-1:0]   lost_cnt_q;
   logic            in_play_q;
   logic            lost_q;

   logic [11:0]     px;
   logic [11:0]     py;
   logic [11:0]     nx;
   logic [11:0]     ny;
   logic            x_uf;
   logic            y_uf;
   logic [11:0]     x_d;
   logic            dir_x_d;
   logic            hit_top;
   logic            hit_pad;
   logic            miss;

   // Candidate next position and collision flags for a MOVE tick
   always_comb begin
      px      = {1'b0, paddle_x_i};
      py      = {2'b00, paddle_y_i};
      nx      = x_q + SX_C;
      ny      = y_q + SY_C;
      x_uf    = 1'b0;
      y_uf    = 1'b0;
      if (!dir_x_q) begin
         nx   = x_q - SX_C;
         x_uf = (x_q < SX_C);
      end
      if (!dir_y_q) begin
         ny   = y_q - SY_C;
         y_uf = (y_q < SY_C);
      end

      x_d     = nx;
      dir_x_d = dir_x_q;
      if (dir_x_q && ((nx + BS_M1) > XMAX_C)) begin
         x_d     = X_RIGHT;
         dir_x_d = 1'b0;
      end else if (!dir_x_q && (x_uf || (nx < XMIN_C))) begin
         x_d     = XMIN_C;
         dir_x_d = 1'b1;
      end

      hit_top = !dir_y_q && (y_uf || (ny < YMIN_C));
      hit_pad = dir_y_q
              && ((y_q + BS_M1) < py)
              && ((ny + BS_M1) >= py)
              && ((nx + BS_M1) >= px)
              && (nx <= (px + PW_M1));
      miss    = dir_y_q && ((ny + BS_M1) > YMAX_C);
   end

   // Serve / move / lost sequencing with registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_SERVE;
         x_q        <= X_RST;
         y_q        <= Y_RST;
         dir_x_q    <= 1'b1;
         dir_y_q    <= 1'b0;
         lost_cnt_q <= '0;
         in_play_q  <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         lost_q <= 1'b0;
         if (frame_tick_i) begin
            unique case (state_q)
               S_SERVE: begin
                  x_q <= px + SERVE_OFS;
                  y_q <= py - BS_C;
                  if (launch_i) begin
                     dir_x_q   <= 1'b1;
                     dir_y_q   <= 1'b0;
                     state_q   <= S_MOVE;
                     in_play_q <= 1'b1;
                  end
               end
               S_MOVE: begin
                  x_q     <= x_d;
                  dir_x_q <= dir_x_d;
                  if (hit_top) begin
                     y_q     <= YMIN_C;
                     dir_y_q <= 1'b1;
                  end else if (hit_pad) begin
                     y_q     <= py - BS_C;
                     dir_y_q <= 1'b0;
                  end else if (miss) begin
                     y_q       <= Y_FLOOR;
                     state_q   <= S_LOST;
                     in_play_q <= 1'b0;
                     lost_q    <= 1'b1;
                  end else begin
                     y_q <= ny;
                  end
               end
               S_LOST: begin
                  if (lost_cnt_q == LOST_LAST) begin
                     lost_cnt_q <= '0;
                     state_q    <= S_SERVE;
                  end else begin
                     lost_cnt_q <= lost_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q   <= S_SERVE;
                  in_play_q <= 1'b0;
               end
            endcase
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{x_q[11], y_q[11:10]};

   assign ball_x_o    = x_q[10:0];
   assign ball_y_o    = y_q[9:0];
   assign in_play_o   = in_play_q;
   assign ball_lost_o = lost_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: frame-level reference model checked every cycle,
// plus hand-computed waypoints along directed serve/bounce/miss runs.
module tb_ball_ctrl;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic        launch;
   logic [10:0] paddle_x;
   logic [9:0]  paddle_y;
   logic [10:0] ball_x;
   logic [9:0]  ball_y;
   logic        in_play;
   logic        ball_lost;

   int checks   = 0;
   int failures = 0;
   bit chk_on   = 1'b0;

   // reference model: 0 serve, 1 move, 2 lost
   int m_st, mx, my, mdx, mdy, mcnt, mlost;

   ball_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .frame_tick_i (frame_tick),
      .launch_i     (launch),
      .paddle_x_i   (paddle_x),
      .paddle_y_i   (paddle_y),
      .ball_x_o     (ball_x),
      .ball_y_o     (ball_y),
      .in_play_o    (in_play),
      .ball_lost_o  (ball_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_st = 0; mx = 708; my = 600; mdx = 1; mdy = -1;
      mcnt = 0; mlost = 0;
   endtask

   task automatic m_step(input int l);
      int px, py, nx, ny;
      px = int'(paddle_x);
      py = int'(paddle_y);
      mlost = 0;
      if (m_st == 0) begin
         mx = px + 48;
         my = py - 25;
         if (l != 0) begin
            mdx = 1; mdy = -1; m_st = 1;
         end
      end else if (m_st == 1) begin
         nx = mx + 4 * mdx;
         ny = my + 4 * mdy;
         if (mdx > 0 && nx + 24 > 1429) begin
            mx = 1405; mdx = -1;
         end else if (mdx < 0 && nx < 10) begin
            mx = 10; mdx = 1;
         end else begin
            mx = nx;
         end
         if (mdy < 0 && ny < 11) begin
            my = 11; mdy = 1;
         end else if (mdy > 0 && my + 24 < py && ny + 24 >= py
                      && nx + 24 >= px && nx <= px + 120) begin
            my = py - 25; mdy = -1;
         end else if (mdy > 0 && ny + 24 > 889) begin
            my = 865; m_st = 2; mlost = 1;
         end else begin
            my = ny;
         end
      end else begin
         mcnt++;
         if (mcnt == 60) begin
            mcnt = 0; m_st = 0;
         end
      end
   endtask

   task automatic tick(input logic l);
      @(negedge clk);
      #1;
      frame_tick = 1'b1;
      launch     = l;
      m_step(int'(l));
      @(negedge clk);
      #1;
      frame_tick = 1'b0;
      launch     = 1'b0;
      mlost      = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_x"}, int'(ball_x), 708);
      chk({tag, "_y"}, int'(ball_y), 600);
      chk({tag, "_play"}, int'(in_play), 0);
      chk({tag, "_lost"}, int'(ball_lost), 0);
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("cmp_x", int'(ball_x), mx);
         chk("cmp_y", int'(ball_y), my);
         chk("cmp_play", int'(in_play), (m_st == 1) ? 1 : 0);
         chk("cmp_lost", int'(ball_lost), mlost);
      end
   end

   initial begin
      rst        = 1'b1;
      frame_tick = 1'b0;
      launch     = 1'b0;
      paddle_x   = 11'd600;
      paddle_y   = 10'd860;
      m_reset();
      #1;
      chk_reset("rst0");
      chk_on = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;

      // serve, launch, first motion
      tick(1'b0);
      chk("serve_x", int'(ball_x), 648);
      chk("serve_y", int'(ball_y), 835);
      chk("serve_play", int'(in_play), 0);
      tick(1'b1);
      chk("launch_play", int'(in_play), 1);
      chk("launch_x", int'(ball_x), 648);
      tick(1'b0);
      chk("mv1_x", int'(ball_x), 652);
      chk("mv1_y", int'(ball_y), 831);

      // right wall, top wall, paddle hit
      paddle_x = 11'd480;
      for (int n = 2; n <= 415; n++) begin
         tick(1'b0);
         case (n)
            189: chk("rw_pre_x", int'(ball_x), 1404);
            190: chk("rw_x", int'(ball_x), 1405);
            191: chk("rw_post_x", int'(ball_x), 1401);
            206: chk("top_eq_y", int'(ball_y), 11);
            207: chk("top_y", int'(ball_y), 11);
            208: chk("top_post_y", int'(ball_y), 15);
            413: chk("pad_pre_y", int'(ball_y), 835);
            414: begin
               chk("pad_y", int'(ball_y), 835);
               chk("pad_x", int'(ball_x), 509);
            end
            415: chk("pad_post_y", int'(ball_y), 831);
            default: ;
         endcase
      end

      // reset mid-flight, no clock edge needed
      @(negedge clk);
      #3;
      rst = 1'b1;
      m_reset();
      #1;
      chk_reset("rst_mid");
      @(negedge clk);
      #1;
      rst = 1'b0;

      // no launch: ball stays parked on paddle
      paddle_x = 11'd600;
      paddle_y = 10'd860;
      for (int k = 0; k < 3; k++) begin
         tick(1'b0);
         chk("park_x", int'(ball_x), 648);
         chk("park_y", int'(ball_y), 835);
         chk("park_play", int'(in_play), 0);
      end

      // right wall, left wall, miss, lost countdown, re-serve
      paddle_x = 11'd1355;
      paddle_y = 10'd625;
      tick(1'b1);
      chk("b_launch_x", int'(ball_x), 1403);
      chk("b_launch_y", int'(ball_y), 600);
      for (int n = 1; n <= 424; n++) begin
         tick(1'b0);
         case (n)
            1: begin
               chk("b_rw_x", int'(ball_x), 1405);
               chk("b_rw_y", int'(ball_y), 596);
            end
            2: chk("b_rw_post_x", int'(ball_x), 1401);
            147: chk("b_top_pre_y", int'(ball_y), 12);
            148: chk("b_top_y", int'(ball_y), 11);
            349: chk("lw_pre_x", int'(ball_x), 13);
            350: chk("lw_x", int'(ball_x), 10);
            351: chk("lw_post_x", int'(ball_x), 14);
            361: begin
               chk("miss_pre_y", int'(ball_y), 863);
               chk("miss_pre_lost", int'(ball_lost), 0);
            end
            362: begin
               chk("miss_y", int'(ball_y), 865);
               chk("miss_x", int'(ball_x), 58);
               chk("miss_lost", int'(ball_lost), 1);
               chk("miss_play", int'(in_play), 0);
            end
            363: begin
               chk("lost_clr", int'(ball_lost), 0);
               chk("lost_hold_y", int'(ball_y), 865);
            end
            422: chk("lost_end_x", int'(ball_x), 58);
            423: begin
               chk("reserve_x", int'(ball_x), 1403);
               chk("reserve_y", int'(ball_y), 600);
               chk("reserve_play", int'(in_play), 0);
            end
            default: ;
         endcase
      end

      repeat (3) @(negedge clk);
      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
